// File: rtl/mem_dump_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_dump_reader_if
// Description : Bundles the RAM byte-read handshake (MFA/MOC) and the
//               assembled-word valid/ready stream of mem_dump_reader.
//               master = reader side, slave = RAM model / word consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_dump_reader_if;
  // RAM byte-read handshake
  logic        mem_mfa;
  logic        mem_rw;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_din;
  logic        mem_moc;
  // Assembled word stream
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic [7:0]  word_addr;

  modport master (
    output mem_mfa,
    output mem_rw,
    output mem_addr,
    input  mem_din,
    input  mem_moc,
    output word_valid,
    input  word_ready,
    output word_data,
    output word_addr
  );

  modport slave (
    input  mem_mfa,
    input  mem_rw,
    input  mem_addr,
    output mem_din,
    output mem_moc,
    input  word_valid,
    output word_ready,
    input  word_data,
    input  word_addr
  );
endinterface
`default_nettype wire

// File: rtl/mem_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : mem_dump_reader
// Description : Walks a word-aligned byte-address window of the RAM, reads
//               four bytes per word over the MFA/MOC handshake, assembles a
//               big-endian 32-bit word and streams it out on valid/ready.
//               All outputs are registered; clr is asynchronous active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_dump_reader #(
  parameter logic [7:0] START_ADDR = 8'd0,
  parameter logic [7:0] LAST_ADDR  = 8'd248
) (
  input  wire logic         clk,
  input  wire logic         clr,
  input  wire logic         start,
  output logic              busy,
  output logic              done,
  mem_dump_reader_if.master bus
);

  localparam logic [7:0] c_WORD_STEP      = 8'd4;
  localparam logic [2:0] c_BYTES_PER_WORD = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_GAP  = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_base;
  logic [7:0]  w_base_next;
  logic [2:0]  r_count;
  logic [2:0]  w_count_next;
  logic [31:0] r_sreg;
  logic [31:0] w_sreg_next;
  logic [7:0]  w_addr_next;

  logic        r_busy;
  logic        r_done;
  logic        r_mfa;
  logic        r_valid;
  logic [7:0]  r_addr;

  // Next-state, window pointer, byte count and shift-register update
  always_comb begin
    w_state_next = r_state;
    w_base_next  = r_base;
    w_count_next = r_count;
    w_sreg_next  = r_sreg;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_base_next  = START_ADDR;
          w_count_next = 3'd0;
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        // mem_din is only meaningful while a request is completing
        if (bus.mem_moc) begin
          w_sreg_next  = {r_sreg[23:0], bus.mem_din};
          w_count_next = r_count + 3'd1;
          w_state_next = S_GAP;
        end
      end
      S_GAP: begin
        // One idle MFA cycle so the RAM sees each byte as a fresh request
        if (r_count == c_BYTES_PER_WORD) begin
          w_state_next = S_EMIT;
        end else begin
          w_state_next = S_REQ;
        end
      end
      S_EMIT: begin
        if (bus.word_ready) begin
          // Equality compare keeps a window ending at 252 from wrapping
          if (r_base == LAST_ADDR) begin
            w_state_next = S_DONE;
          end else begin
            w_base_next  = r_base + c_WORD_STEP;
            w_count_next = 3'd0;
            w_state_next = S_REQ;
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Byte address presented with the next request (8-bit modulo)
  assign w_addr_next = w_base_next + {6'd0, w_count_next[1:0]};

  // State register; outputs are registered from the next state so they
  // change on the same edge as the state they describe
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_base  <= 8'd0;
      r_count <= 3'd0;
      r_sreg  <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mfa   <= 1'b0;
      r_valid <= 1'b0;
      r_addr  <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_base  <= w_base_next;
      r_count <= w_count_next;
      r_sreg  <= w_sreg_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= (w_state_next == S_DONE);
      r_mfa   <= (w_state_next == S_REQ);
      r_valid <= (w_state_next == S_EMIT);
      r_addr  <= w_addr_next;
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign bus.mem_mfa    = r_mfa;
  assign bus.mem_rw     = 1'b1;
  assign bus.mem_addr   = r_addr;
  assign bus.word_valid = r_valid;
  assign bus.word_data  = r_sreg;
  assign bus.word_addr  = r_base;

endmodule
`default_nettype wire

// File: doc/mem_dump_reader.md
# mem_dump_reader

Hardware readback engine for the byte-addressed RAM. It walks a word-aligned address window, performs four byte reads per word over the RAM's MFA/MOC handshake, and assembles each big-endian 32-bit word. Each word is streamed out on a valid/ready port. It is the read-side counterpart of the RAM preload path and gives benches and debug logic a cycle-accurate memory dump without hierarchical peeks.

## Interface
Parameters:
- START_ADDR, 8'd0, first word address; multiple of 4.
- LAST_ADDR, 8'd248, last word address dumped, inclusive; multiple of 4; START_ADDR <= LAST_ADDR.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- clr  in  1  reset, asynchronous, active-low.
- start  in  1  begin a dump; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.
- mem_mfa  out  1  memory function active; request a byte read.
- mem_rw  out  1  constant 1 (read); this block never writes RAM.
- mem_addr  out  8  byte address of the current request.
- mem_din  in  8  byte returned by RAM; valid when mem_moc=1.
- mem_moc  in  1  memory operation complete.
- word_valid  out  1  word_data/word_addr valid.
- word_ready  in  1  consumer accepts the word when high with word_valid.
- word_data  out  32  assembled word: {Mem[a], Mem[a+1], Mem[a+2], Mem[a+3]}.
- word_addr  out  8  word address a of word_data.

## Operation
- Internal state: base (8b word address), bidx (2b byte index plus a 3-bit count), shift register sreg (32b).
- States: IDLE, REQ, GAP, EMIT, DONE.
- IDLE: start=1 loads base=START_ADDR, count=0, and goes to REQ. Otherwise stays in IDLE.
- REQ: mem_mfa=1, mem_addr=base+count[1:0].
  - On mem_moc=1: sreg <= {sreg[23:0], mem_din}, count++, go to GAP.
  - Else hold REQ with mem_addr stable.
- GAP: mem_mfa=0 for exactly one cycle so RAM sees a fresh request.
  - If count==4: go to EMIT.
  - Else: go to REQ.
- EMIT: word_valid=1, word_data=sreg, word_addr=base; these outputs are stable while ready is low.
  - On word_ready=1:
    - If base==LAST_ADDR: go to DONE.
    - Else: base += 4 (8-bit, wraps mod 256), count=0, go to REQ.
- DONE: done=1 for one cycle, then go to IDLE. word_valid=0.
- Address arithmetic is 8-bit modulo. Termination uses an equality compare with LAST_ADDR, so a window ending at 8'd252 completes without wrap issues.
- start is ignored outside IDLE. mem_din is ignored unless state is REQ and mem_moc=1.

## Timing
- Reset (clr=0, async): state=IDLE, busy=0, done=0, mem_mfa=0, mem_rw=1, mem_addr=0, word_valid=0, word_data=0, word_addr=0, base=0, count=0, sreg=0.
- Reset mid-operation aborts immediately. mem_mfa drops asynchronously and any partial word is discarded. After clr deasserts, the block waits in IDLE for a new start.
- start sampled at edge N: mem_mfa=1 from edge N.
- Per byte: minimum 2 cycles (REQ with same-cycle moc, then GAP). Each cycle of moc delay adds 1 cycle.
- Per word: minimum 8 cycles, plus at least 1 EMIT cycle.
- Minimum dump time: (LAST_ADDR-START_ADDR)/4+1 words × 9 cycles, plus 1 DONE cycle.
- Outputs are registered. word_valid never deasserts without handshake acceptance, except on reset.
- done and word_valid are never high in the same cycle.

## Test plan
- Reset values: hold clr=0 with random inputs -> every output at its reset value; clr=0 asserted in REQ drops mem_mfa before the next clk edge.
- Single word: START=LAST=0, Mem[0..3]=E3,A0,10,04, moc same cycle, ready=1 -> word_data=32'hE3A01004, word_addr=0, done pulse 10 cycles after start.
- Backpressure: hold ready=0 for 5 cycles in EMIT -> word_valid, word_data, word_addr stable; no mem_mfa during the stall; next word's request starts the cycle after acceptance.
- Slow memory: moc delayed 3 cycles per byte -> mem_addr held each request; mem_addr sequence 4,5,6,7; word correct; 20 cycles per word.
- Full window: defaults, Mem[i]=i -> 63 words; word k = {4k,4k+1,4k+2,4k+3}; exactly one done pulse.
- Top wrap: START=LAST=252 -> addresses 252..255 read, single word emitted, no address 0 access, done asserted; start pulses during busy are ignored.
